// File: rtl/mc_control.sv
// Multicycle MIPS-style control FSM with memory wait counter.
// Define MC_CONTROL_EXC_EN to enable the EXC state (unknown opcode and memory timeout traps).
module mc_control #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       exception,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_EXC      = 4'd12
  } state_e;

  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_st, timeout;

  always_comb begin
    mem_st  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // Counter only runs while stalled in a memory state; any other cycle clears it.
    cnt_d   = (mem_st && !mem_ready) ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE) : '0;
`ifdef MC_CONTROL_EXC_EN
    timeout = (TIMEOUT > 0) && mem_st && !mem_ready && (cnt_q == TO_M1);
`else
    timeout = 1'b0;
`endif
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          6'd35, 6'd43: state_d = S_MEM_ADDR;
          6'd0:         state_d = S_R_EXEC;
          6'd4:         state_d = S_BRANCH;
          6'd2:         state_d = S_JUMP;
          6'd8:         state_d = S_ADDI_EX;
`ifdef MC_CONTROL_EXC_EN
          default:      state_d = S_EXC;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == 6'd35) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_d = S_R_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_EXC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    exception     = 1'b0;
    state         = reset ? 4'd0 : state_q;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = 2'b11;
        S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
        S_MEM_RD:   begin mem_read = 1'b1; i_or_d = 1'b1; end
        S_MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
        S_MEM_WR:   begin mem_write = 1'b1; i_or_d = 1'b1; end
        S_R_EXEC:   begin alu_src_a = 1'b1; alu_op = 2'b10; end
        S_R_WB:     begin reg_write = 1'b1; reg_dst = 1'b1; end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
        end
        S_JUMP:     begin pc_write = 1'b1; pc_src = 2'b10; end
        S_ADDI_EX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
        S_ADDI_WB:  reg_write = 1'b1;
`ifdef MC_CONTROL_EXC_EN
        S_EXC:      begin exception = 1'b1; pc_write = 1'b1; pc_src = 2'b11; end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter TIMEOUT, default 15: memory wait limit in cycles; 0 disables timeout.
REQ-002 Parameter CNT_W, default 4: wait counter width; SHALL satisfy 2^CNT_W > TIMEOUT.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 opcode  input  6  instruction opcode from instruction register, sampled in DECODE.
REQ-006 mem_ready  input  1  memory completes current read/write this cycle.
REQ-007 pc_write, pc_write_cond  output  1 each  unconditional / branch-qualified PC load.
REQ-008 pc_src  output  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
REQ-009 i_or_d, mem_read, mem_write, ir_write  output  1 each  memory address select (0 PC, 1 ALUOut), read, write, IR load.
REQ-010 mem_to_reg, reg_dst, reg_write  output  1 each  register file controls.
REQ-011 alu_src_a  output  1 (0 PC, 1 rs); alu_src_b  output  2 (00 rt, 01 const 4, 10 imm, 11 imm<<2); alu_op  output  2 (00 add, 01 sub, 10 funct).
REQ-012 exception  output  1  high for the one cycle spent in EXC.
REQ-013 state  output  4  current FSM state code.

Function
REQ-014 States/codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, EXC 12; codes 13-15 SHALL go to FETCH next cycle with all outputs 0.
REQ-015 Outputs SHALL be combinational from state (plus mem_ready where stated); every output not listed for a state SHALL be 0.
REQ-016 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready; stay until mem_ready=1, then DECODE.
REQ-017 DECODE: alu_src_b=11, alu_op=00; next by opcode: 35,43 -> MEM_ADDR; 0 -> R_EXEC; 4 -> BRANCH; 2 -> JUMP; 8 -> ADDI_EXEC; other -> EXC (see REQ-027).
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_RD if opcode=35, else MEM_WR.
REQ-019 MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB. MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready, then FETCH.
REQ-020 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
REQ-021 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB; R_WB: reg_write=1, reg_dst=1 -> FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01 -> FETCH.
REQ-023 JUMP: pc_write=1, pc_src=10 -> FETCH.
REQ-024 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB; ADDI_WB: reg_write=1, reg_dst=0 -> FETCH.
REQ-025 Latency without waits: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
REQ-026 Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle in those states with mem_ready=0; saturates at 2^CNT_W-1.
REQ-027 Timeout: in a memory state with mem_ready=0 and counter = TIMEOUT-1 (TIMEOUT>0), next state SHALL be EXC; mem_ready=1 in same cycle wins.

Reset
REQ-028 While reset=1 all outputs SHALL be 0; at the rising edge with reset=1, state <= FETCH and counter <= 0, overriding any transition, including mid-wait.

Configuration
REQ-029 Macro MC_CONTROL_EXC_EN defined: EXC state present; EXC drives exception=1, pc_write=1, pc_src=11 for one cycle, then FETCH.
REQ-030 Macro undefined: EXC unreachable; unknown opcode goes DECODE -> FETCH (NOP); timeout ignored, memory states wait indefinitely; exception tied 0.

Verification
REQ-031 reset high 2 cycles, release, mem_ready=1 -> state 0, all outputs 0 during reset; FETCH asserts mem_read, ir_write, pc_write.
REQ-032 opcode=35, mem_ready=1 -> states 0,1,2,3,4,0; MEM_WB reg_write=1, mem_to_reg=1.
REQ-033 opcode=43, mem_ready low 3 cycles in MEM_WR -> mem_write held 4 cycles, then FETCH; reg_write never 1.
REQ-034 EXC_EN, opcode=63 -> DECODE then EXC with exception=1, pc_src=11, then FETCH; without macro -> DECODE then FETCH.
REQ-035 EXC_EN, TIMEOUT=15, mem_ready=0 in FETCH -> EXC after exactly 15 cycles in FETCH; repeat with mem_ready=1 on 15th cycle -> DECODE.
REQ-036 reset asserted during MEM_RD wait -> state 0 next cycle, counter 0.
